// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches under a credit limit, buffers
// in-order responses in a small prefetch FIFO and handles pipeline redirects
// by flushing the FIFO and draining responses that are still in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SW  = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  logic [31:0]   tag_q  [DEPTH];
  logic [31:0]   tag_d  [DEPTH];

  logic          credit_ok;
  logic          issue;
  logic          rsp;
  logic          accept;
  logic          pop;
  logic [CW-1:0] tag_wr_idx;
  logic [CW-1:0] fifo_wr_idx;
  logic          unused_pc_bits;

  // Request/handshake qualifiers; in-flight plus buffered words never exceed DEPTH
  assign credit_ok   = ({1'b0, out_q} + {1'b0, fcnt_q}) < SW'(DEPTH);
  assign imem_req    = reset & (state_q == FETCH) & credit_ok & ~redirect;
  assign imem_addr   = fpc_q;
  assign issue       = imem_req & imem_gnt;
  assign rsp         = imem_rvalid & (out_q != '0);
  assign accept      = rsp & (drop_q == '0) & ~redirect;
  assign instr_valid = (fcnt_q != '0);
  assign pop         = instr_valid & ~stall;
  assign instr_out   = instr_valid ? fifo_q[0].instr : NOP;
  assign pc_out      = instr_valid ? fifo_q[0].pc : 32'h0000_0000;

  // Low address bits of a redirect target are ignored
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Next-state logic for FSM, fetch PC, counters, tag queue and FIFO
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    out_d       = out_q + CW'(issue) - CW'(rsp);
    drop_d      = drop_q;
    fcnt_d      = fcnt_q;
    fifo_d      = fifo_q;
    tag_d       = tag_q;
    tag_wr_idx  = out_q - CW'(rsp);
    fifo_wr_idx = fcnt_q - CW'(pop);

    // Tag queue tracks the PC of every outstanding request, oldest first
    if (rsp) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        tag_d[i] = tag_q[i + 1];
      end
    end
    if (issue) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == tag_wr_idx) begin
          tag_d[i] = fpc_q;
        end
      end
    end

    if (redirect) begin
      fpc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      fpc_d = fpc_q + 32'd4;
    end

    // Prefetch FIFO: head at index 0, shift on pop, write behind the tail
    if (redirect) begin
      fcnt_d = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          fifo_d[i] = fifo_q[i + 1];
        end
      end
      if (accept) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == fifo_wr_idx) begin
            fifo_d[i] = '{pc: tag_q[0], instr: imem_rdata};
          end
        end
      end
      fcnt_d = fcnt_q + CW'(accept) - CW'(pop);
    end

    // Every word still in flight after a redirect belongs to the old path
    if (redirect) begin
      drop_d  = out_d;
      state_d = (out_d != '0) ? DRAIN : FETCH;
    end else begin
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if ((state_q == DRAIN) && (drop_d == '0)) begin
        state_d = FETCH;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      fcnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      fpc_q  <= fpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      fcnt_q <= fcnt_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small in-order memory model.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0080;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int compared;
  int mismatched;

  // Memory model controls and pending-response queue (addresses, oldest first)
  logic        gnt_en;
  logic        resp_en;
  logic [31:0] pend_q [$];

  // Per-cycle samples taken before the rising edge
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic        s_issued;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_1111;
  endfunction

  // One clock cycle: drive memory side, sample, clock, update memory queue
  task automatic cycle();
    imem_gnt = gnt_en;
    if (resp_en && (pend_q.size() > 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_valid  = instr_valid;
    s_pc     = pc_out;
    s_instr  = instr_out;
    s_issued = imem_req & imem_gnt;
    @(posedge clk);
    if (imem_rvalid) void'(pend_q.pop_front());
    if (s_issued) pend_q.push_back(s_addr);
    compared++;
    if (pend_q.size() > DEPTH) begin
      mismatched++;
      $display("FAIL credit_limit outstanding=%0d allowed=%0d", pend_q.size(), DEPTH);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    gnt_en      = 1'b0;
    resp_en     = 1'b0;
    pend_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl req=%0b valid=%0b want 0/0", imem_req, instr_valid);
    end
    compared++;
    if (instr_out !== NOP || pc_out !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_out instr=%h pc=%h want %h/0", instr_out, pc_out, NOP);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      mismatched++;
      $display("FAIL reset_release req=%0b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    gnt_en  = 1'b1;
    resp_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      compared++;
      if (s_req !== 1'b1 || s_addr !== RESET_PC + 32'(4 * k)) begin
        mismatched++;
        $display("FAIL stream_req c%0d req=%0b addr=%h want 1/%h", k, s_req, s_addr,
                 RESET_PC + 32'(4 * k));
      end
      compared++;
      if (s_valid !== (k >= 2)) begin
        mismatched++;
        $display("FAIL stream_valid c%0d got %0b want %0b", k, s_valid, (k >= 2));
      end
      if (k >= 2) begin
        exp_pc = RESET_PC + 32'(4 * (k - 2));
        compared++;
        if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
          mismatched++;
          $display("FAIL stream_data c%0d pc=%h instr=%h want %h/%h", k, s_pc, s_instr,
                   exp_pc, mem_word(exp_pc));
        end
      end
    end
  endtask

  // Continues from test_stream: head is 32'hA8 when the stall begins
  task automatic test_stall();
    logic [31:0] exp_pc;
    int          n;
    stall = 1'b1;
    cycle();
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      compared++;
      if (s_req !== 1'b0 || s_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_hold c%0d req=%0b valid=%0b want 0/1", k, s_req, s_valid);
      end
      compared++;
      if (s_pc !== 32'h0000_00A8 || s_instr !== mem_word(32'h0000_00A8)) begin
        mismatched++;
        $display("FAIL stall_data c%0d pc=%h instr=%h want 000000a8/%h", k, s_pc, s_instr,
                 mem_word(32'h0000_00A8));
      end
    end
    stall  = 1'b0;
    exp_pc = 32'h0000_00A8;
    n      = 0;
    for (int k = 0; k < 12 && n < 5; k++) begin
      cycle();
      if (s_valid) begin
        compared++;
        if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
          mismatched++;
          $display("FAIL stall_release pc=%h instr=%h want %h/%h", s_pc, s_instr, exp_pc,
                   mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        n++;
      end
    end
    compared++;
    if (n != 5) begin
      mismatched++;
      $display("FAIL stall_release_count got %0d want 5", n);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    gnt_en  = 1'b1;
    resp_en = 1'b0;
    cycle();
    cycle();
    gnt_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    compared++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_cycle req=%0b valid=%0b want 0/0", s_req, s_valid);
    end
    gnt_en  = 1'b1;
    resp_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      compared++;
      if (s_req !== 1'b0 || s_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL redir_drain d%0d req=%0b valid=%0b want 0/0", k, s_req, s_valid);
      end
    end
    cycle();
    compared++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_0100 || s_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_refetch req=%0b addr=%h valid=%0b want 1/00000100/0", s_req,
               s_addr, s_valid);
    end
    cycle();
    compared++;
    if (s_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_gap valid=%0b want 0", s_valid);
    end
    cycle();
    compared++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0000_0100 || s_instr !== mem_word(32'h0000_0100)) begin
      mismatched++;
      $display("FAIL redir_first valid=%0b pc=%h instr=%h want 1/00000100/%h", s_valid, s_pc,
               s_instr, mem_word(32'h0000_0100));
    end
    cycle();
    compared++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0000_0104) begin
      mismatched++;
      $display("FAIL redir_second valid=%0b pc=%h want 1/00000104", s_valid, s_pc);
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    gnt_en  = 1'b1;
    resp_en = 1'b0;
    cycle();
    cycle();
    resp_en     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    cycle();
    redirect = 1'b0;
    resp_en  = 1'b0;
    cycle();
    compared++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL collide_hold req=%0b valid=%0b want 0/0", s_req, s_valid);
    end
    resp_en = 1'b1;
    cycle();
    compared++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL collide_drop req=%0b valid=%0b want 0/0", s_req, s_valid);
    end
    cycle();
    compared++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_0200) begin
      mismatched++;
      $display("FAIL collide_refetch req=%0b addr=%h want 1/00000200", s_req, s_addr);
    end
    cycle();
    cycle();
    compared++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0000_0200 || s_instr !== mem_word(32'h0000_0200)) begin
      mismatched++;
      $display("FAIL collide_first valid=%0b pc=%h instr=%h want 1/00000200/%h", s_valid,
               s_pc, s_instr, mem_word(32'h0000_0200));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    do_reset();
    resp_en     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    gnt_en   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k < 3) begin
        compared++;
        if (s_req !== 1'b1 || s_addr !== exp_addr[k]) begin
          mismatched++;
          $display("FAIL wrap_addr c%0d req=%0b addr=%h want 1/%h", k, s_req, s_addr,
                   exp_addr[k]);
        end
      end
      if (k >= 2) begin
        compared++;
        if (s_valid !== 1'b1 || s_pc !== exp_addr[k - 2]) begin
          mismatched++;
          $display("FAIL wrap_pc c%0d valid=%0b pc=%h want 1/%h", k, s_valid, s_pc,
                   exp_addr[k - 2]);
        end
      end
    end
  endtask

  task automatic test_reset_midfetch();
    logic found;
    do_reset();
    gnt_en      = 1'b1;
    resp_en     = 1'b1;
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    cycle();
    redirect = 1'b0;
    cycle();
    cycle();
    resp_en = 1'b0;
    cycle();
    cycle();
    compared++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0000_0300 || pend_q.size() != 2) begin
      mismatched++;
      $display("FAIL midfetch_setup valid=%0b pc=%h outstanding=%0d want 1/00000300/2",
               s_valid, s_pc, pend_q.size());
    end
    reset = 1'b0;
    #1;
    compared++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'h0) begin
      mismatched++;
      $display("FAIL midfetch_reset req=%0b valid=%0b instr=%h pc=%h want 0/0/%h/0", imem_req,
               instr_valid, instr_out, pc_out, NOP);
    end
    pend_q.delete();
    imem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    stall   = 1'b0;
    gnt_en  = 1'b1;
    resp_en = 1'b1;
    cycle();
    compared++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      mismatched++;
      $display("FAIL midfetch_restart req=%0b addr=%h want 1/%h", s_req, s_addr, RESET_PC);
    end
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cycle();
      if (s_valid) begin
        found = 1'b1;
        compared++;
        if (s_pc !== RESET_PC || s_instr !== mem_word(RESET_PC)) begin
          mismatched++;
          $display("FAIL midfetch_first pc=%h instr=%h want %h/%h", s_pc, s_instr, RESET_PC,
                   mem_word(RESET_PC));
        end
      end
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL midfetch_timeout valid=0 want 1 within 6 cycles");
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    gnt_en      = 1'b0;
    resp_en     = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_collide();
    test_wrap();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

endmodule
